blink_decode: RTL and testbench

- Receiver for the LED blink-code protocol.
- Samples a single blinking line, locks onto the fast-toggle preamble, counts the column and row pulse trains, and presents the recovered (col,row) pair with a one-cycle valid strobe.
- Sits on the bench/loopback side of the LED blink encoder; also usable on a photodiode input in the same clock domain.

---
 rtl/blink_decode.sv | 189 ++++++++++++++++++
 tb/tb_blink_decode.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/blink_decode.sv
// -----------------------------------------------------------------------------
// blink_decode
//   Receiver for the LED blink-code protocol. The blink line is synchronised
//   into clk, a run of fast toggles (the preamble) arms the decoder, then two
//   pulse trains are counted: the column field and the row field. Each field
//   is closed by a long low gap. After the row gap the recovered (col,row)
//   pair is presented together with a one-cycle valid strobe.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   led_in     in   blink line, asynchronous to clk
//   col[6:0]   out  last decoded column
//   row[6:0]   out  last decoded row
//   valid      out  one-cycle strobe, col/row updated this cycle
//   frame_err  out  one-cycle strobe, frame aborted
//   locked     out  high after a good frame, low after an error
// -----------------------------------------------------------------------------
module blink_decode #(
  parameter int SLOT_CLKS = 16,
  parameter int PRE_MIN   = 16,
  parameter int MIN_HIGH  = 4,
  parameter int MAX_HIGH  = 12,
  parameter int GAP_CLKS  = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       led_in,
  output logic [6:0] col,
  output logic [6:0] row,
  output logic       valid,
  output logic       frame_err,
  output logic       locked
);

  localparam int TOG_W = $clog2(PRE_MIN + 1);
  // High counter saturates one past the legal maximum so over-long pulses
  // stay visibly over-long.
  localparam int HI_W  = $clog2(MAX_HIGH + 2);
  // Low counter is sized with one slot of headroom above the gap threshold;
  // it saturates at the threshold.
  localparam int LO_W  = $clog2(GAP_CLKS + SLOT_CLKS + 1);

  localparam logic [TOG_W-1:0] TOG_SAT = TOG_W'(PRE_MIN);
  localparam logic [HI_W-1:0]  HI_MIN  = HI_W'(MIN_HIGH);
  localparam logic [HI_W-1:0]  HI_MAX  = HI_W'(MAX_HIGH);
  localparam logic [HI_W-1:0]  HI_SAT  = HI_W'(MAX_HIGH + 1);
  localparam logic [LO_W-1:0]  LO_GAP  = LO_W'(GAP_CLKS);
  localparam logic [6:0]       CNT_MAX = 7'd127;

  localparam logic [1:0] S_HUNT = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_COL  = 2'd2;
  localparam logic [1:0] S_ROW  = 2'd3;

  logic              r_sync_p0;
  logic              r_sync_p1;
  logic              r_prev_p2;
  logic [TOG_W-1:0]  r_tog;
  logic [1:0]        r_state;
  logic [HI_W-1:0]   r_hi;
  logic [LO_W-1:0]   r_lo;
  logic [6:0]        r_col_cnt;
  logic [6:0]        r_row_cnt;
  logic              r_done;

  logic              w_s;
  logic              w_toggle;
  logic              w_fall;
  logic              w_in_field;
  logic              w_hi_bad;
  logic              w_pulse_ok;
  logic [6:0]        w_fld;
  logic              w_ovf;
  logic              w_err;
  logic              w_gap;

  assign w_s        = r_sync_p1;
  assign w_toggle   = w_s ^ r_prev_p2;
  assign w_fall     = r_prev_p2 & ~w_s;
  assign w_in_field = (r_state == S_COL) || (r_state == S_ROW);

  // A pulse is bad if it ends outside the legal width window, or if it is
  // still high after already exceeding the maximum width.
  assign w_hi_bad   = (w_fall && ((r_hi < HI_MIN) || (r_hi > HI_MAX))) ||
                      (w_s && (r_hi > HI_MAX));
  assign w_pulse_ok = w_fall && !w_hi_bad;
  assign w_fld      = (r_state == S_COL) ? r_col_cnt : r_row_cnt;
  // A 128th pulse has no representation; reject instead of wrapping.
  assign w_ovf      = w_pulse_ok && (w_fld == CNT_MAX);
  assign w_err      = w_in_field && (w_hi_bad || w_ovf);
  assign w_gap      = w_in_field && (r_lo == LO_GAP);

  // ---- stage p0/p1: synchroniser; p2: previous sample and toggle run ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
      r_prev_p2 <= 1'b0;
      r_tog     <= '0;
    end else begin
      r_sync_p0 <= led_in;
      r_sync_p1 <= r_sync_p0;
      r_prev_p2 <= r_sync_p1;
      // Runs in every state so a preamble that aborts a field can still lock.
      if (w_toggle)
        r_tog <= (r_tog == TOG_SAT) ? r_tog : r_tog + TOG_W'(1);
      else
        r_tog <= '0;
    end
  end

  // ---- frame state machine, pulse engine and output registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_HUNT;
      r_hi      <= '0;
      r_lo      <= '0;
      r_col_cnt <= '0;
      r_row_cnt <= '0;
      r_done    <= 1'b0;
      col       <= '0;
      row       <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      locked    <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      r_done    <= 1'b0;

      // Publish one clock after the row gap closes the frame.
      if (r_done) begin
        col    <= r_col_cnt;
        row    <= r_row_cnt;
        valid  <= 1'b1;
        locked <= 1'b1;
      end

      case (r_state)
        S_HUNT: begin
          if (r_tog == TOG_SAT)
            r_state <= S_PRE;
        end

        S_PRE: begin
          if (!w_toggle) begin
            r_state   <= S_COL;
            r_col_cnt <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
          end
        end

        default: begin
          if (w_s) begin
            r_hi <= (r_hi == HI_SAT) ? r_hi : r_hi + HI_W'(1);
            r_lo <= '0;
          end else begin
            r_lo <= (r_lo == LO_GAP) ? r_lo : r_lo + LO_W'(1);
            r_hi <= '0;
          end

          // Error wins over a field close in the same clock.
          if (w_err) begin
            frame_err <= 1'b1;
            locked    <= 1'b0;
            r_state   <= S_HUNT;
          end else if (w_gap) begin
            if (r_state == S_COL) begin
              r_state   <= S_ROW;
              r_row_cnt <= '0;
              r_lo      <= '0;
            end else begin
              r_state <= S_HUNT;
              r_done  <= 1'b1;
            end
          end else if (w_pulse_ok) begin
            if (r_state == S_COL)
              r_col_cnt <= r_col_cnt + 7'd1;
            else
              r_row_cnt <= r_row_cnt + 7'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blink_decode.sv
// -----------------------------------------------------------------------------
// tb_blink_decode
//   Directed bench for blink_decode. The line is driven one level per clock
//   on the falling edge; outputs are sampled on the falling edge. Expected
//   values are written by hand from the protocol: 48-clock toggling preamble,
//   pulses of 8 low + 8 high clocks, 32-clock low pauses closing each field.
// -----------------------------------------------------------------------------
module tb_blink_decode;

  logic       clk = 1'b0;
  logic       reset;
  logic       led_in;
  logic [6:0] col;
  logic [6:0] row;
  logic       valid;
  logic       frame_err;
  logic       locked;

  always #5 clk = ~clk;

  blink_decode #(
    .SLOT_CLKS (16),
    .PRE_MIN   (16),
    .MIN_HIGH  (4),
    .MAX_HIGH  (12),
    .GAP_CLKS  (24)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .led_in    (led_in),
    .col       (col),
    .row       (row),
    .valid     (valid),
    .frame_err (frame_err),
    .locked    (locked)
  );

  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         n_vld = 0;
  int         n_err = 0;
  int         vld_cyc = 0;
  int         err_cyc = 0;
  int         last_fall = 0;
  int         last_rise = 0;
  logic [6:0] v_col = '0;
  logic [6:0] v_row = '0;
  logic       both = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      n_vld   <= n_vld + 1;
      v_col   <= col;
      v_row   <= row;
      vld_cyc <= cyc;
    end
    if (frame_err) begin
      n_err   <= n_err + 1;
      err_cyc <= cyc;
    end
    if (valid && frame_err)
      both <= 1'b1;
  end

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive level v for n clocks; remember the cycle each edge reaches the DUT.
  task automatic put(input logic v, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (v && !led_in) last_rise = cyc + 1;
      if (!v && led_in) last_fall = cyc + 1;
      led_in = v;
    end
  endtask

  task automatic preamble();
    for (int i = 0; i < 48; i++)
      put((i % 2 == 0) ? 1'b1 : 1'b0, 1);
  endtask

  task automatic pulse(input int hi_len);
    put(1'b0, 8);
    put(1'b1, hi_len);
  endtask

  task automatic pause();
    put(1'b0, 32);
  endtask

  task automatic frame(input int c, input int r);
    preamble();
    repeat (c) pulse(8);
    pause();
    repeat (r) pulse(8);
    pause();
  endtask

  task automatic expect_frame(input string tag, input int c, input int r,
                              input int exp_err);
    int v0;
    int e0;
    v0 = n_vld;
    e0 = n_err;
    frame(c, r);
    chk_eq({tag, " valid count"}, n_vld - v0, 1);
    chk_eq({tag, " col"}, int'(v_col), c);
    chk_eq({tag, " row"}, int'(v_row), r);
    chk_eq({tag, " frame_err count"}, n_err - e0, exp_err);
    chk_eq({tag, " locked"}, int'(locked), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int e0;
    int f;
    int r0;

    reset  = 1'b1;
    led_in = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("reset col", int'(col), 0);
    chk_eq("reset row", int'(row), 0);
    chk_eq("reset valid", int'(valid), 0);
    chk_eq("reset frame_err", int'(frame_err), 0);
    chk_eq("reset locked", int'(locked), 0);
    reset = 1'b0;
    put(1'b0, 40);

    // Ideal frame, plus end-to-end latency from the last row pulse fall.
    expect_frame("ideal 5,3", 5, 3, 0);
    chk_eq("ideal latency", vld_cyc - last_fall, 27);

    // Back-to-back frames including empty fields and large counts.
    expect_frame("b2b 0,0", 0, 0, 0);
    expect_frame("b2b 0,9", 0, 9, 0);
    expect_frame("b2b 120,120", 120, 120, 0);

    // Third column pulse only 2 clocks wide.
    v0 = n_vld;
    e0 = n_err;
    preamble();
    pulse(8);
    pulse(8);
    pulse(2);
    put(1'b0, 8);
    f = last_fall;
    put(1'b1, 8);
    pause();
    pulse(8);
    pause();
    chk_eq("short pulse frame_err count", n_err - e0, 1);
    chk_eq("short pulse err timing", err_cyc - f, 2);
    chk_eq("short pulse valid count", n_vld - v0, 0);
    chk_eq("short pulse locked", int'(locked), 0);
    chk_eq("short pulse col hold", int'(col), 120);
    chk_eq("short pulse row hold", int'(row), 120);
    expect_frame("after short 2,6", 2, 6, 0);

    // Row pulse stuck high for 20 clocks.
    v0 = n_vld;
    e0 = n_err;
    preamble();
    repeat (3) pulse(8);
    pause();
    pulse(8);
    put(1'b0, 8);
    put(1'b1, 20);
    r0 = last_rise;
    pause();
    chk_eq("long pulse frame_err count", n_err - e0, 1);
    chk_eq("long pulse err timing", err_cyc - r0, 15);
    chk_eq("long pulse valid count", n_vld - v0, 0);
    chk_eq("long pulse col hold", int'(col), 2);
    chk_eq("long pulse row hold", int'(row), 6);
    chk_eq("long pulse locked", int'(locked), 0);

    // One-clock reset in the middle of a column field.
    e0 = n_err;
    preamble();
    repeat (3) pulse(8);
    @(negedge clk);
    reset  = 1'b1;
    led_in = 1'b0;
    @(negedge clk);
    chk_eq("midreset col", int'(col), 0);
    chk_eq("midreset row", int'(row), 0);
    chk_eq("midreset valid", int'(valid), 0);
    chk_eq("midreset frame_err", int'(frame_err), 0);
    chk_eq("midreset locked", int'(locked), 0);
    reset = 1'b0;
    put(1'b0, 40);
    chk_eq("midreset no frame_err", n_err - e0, 0);
    expect_frame("after reset 7,1", 7, 1, 0);

    // Preamble arriving after two column pulses aborts, then relocks.
    preamble();
    pulse(8);
    pulse(8);
    put(1'b0, 4);
    expect_frame("preamble inject 3,2", 3, 2, 1);

    // Field count boundary: 127 is legal, a 128th pulse is an error.
    expect_frame("max 127,1", 127, 1, 0);
    v0 = n_vld;
    e0 = n_err;
    frame(128, 0);
    chk_eq("overflow frame_err count", n_err - e0, 1);
    chk_eq("overflow valid count", n_vld - v0, 0);
    chk_eq("overflow col hold", int'(col), 127);
    chk_eq("overflow row hold", int'(row), 1);
    chk_eq("overflow locked", int'(locked), 0);

    chk_eq("valid with frame_err", int'(both), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
